// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR) load the output register on the
// accept edge. MUL is a shift-add multiply that retires one multiplier bit per
// clock and lands its result WIDTH edges after accept.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer side is in_valid/in_ready and the consumer side is
// out_valid/out_ready. in_ready never depends on in_valid. While out_valid is
// high and out_ready is low, the output is held stable.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             o_dbg_state
);
  localparam int SW  = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic { S_IDLE = 1'b0, S_BUSY = 1'b1 } state_t;

  state_t             r_state, w_state_next;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry, r_zero, r_neg, r_ovf;
  logic [2*WIDTH-1:0] r_mcand, r_prod, w_prod_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic               w_accept, w_drain, w_is_mul, w_mul_done;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;
  logic [WIDTH:0]     w_sum, w_shl, w_shr;
  logic [SW-1:0]      w_amt;

  // Reset low also blocks acceptance so nothing is taken while held in reset.
  assign in_ready    = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_drain     = r_out_valid && out_ready;
  assign w_is_mul    = (sel == 3'b111);
  assign w_mul_done  = (r_state == S_BUSY) && (r_cnt == CW'(1));
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign carry       = r_carry;
  assign zero        = r_zero;
  assign neg         = r_neg;
  assign ovf         = r_ovf;
  assign o_dbg_state = (r_state == S_BUSY);

  // Single-cycle datapath: result, carry and overflow for the presented opcode.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_sum = '0;
    w_shl = '0;
    w_shr = '0;
    w_amt = b[SW-1:0];
    case (sel)
      3'b000: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      3'b001: begin
        // Bit WIDTH of the extended difference is the borrow (a < b).
        w_sum = {1'b0, a} - {1'b0, b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      3'b010: w_res = a & b;
      3'b011: w_res = a | b;
      3'b100: w_res = a ^ b;
      3'b101: begin
        // The extra top bit catches the last bit shifted out (a[WIDTH-s]).
        w_shl = {1'b0, a} << w_amt;
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      3'b110: begin
        // The extra bottom bit catches the last bit shifted out (a[s-1]).
        w_shr = {a, 1'b0} >> w_amt;
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      default: ;
    endcase
  end

  // FSM next state: IDLE goes BUSY on a MUL accept, BUSY returns after WIDTH steps.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_next = S_BUSY;
      S_BUSY: if (w_mul_done)           w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Multiplier: load operands on accept, then add/shift one multiplier bit per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (r_state == S_BUSY) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Output register: load on single-cycle accept or multiply completion, else clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_carry     <= w_c;
      r_zero      <= (w_res == '0);
      r_neg       <= w_res[MSB];
      r_ovf       <= w_v;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_prod_next[WIDTH-1:0];
      r_carry     <= |w_prod_next[2*WIDTH-1:WIDTH];
      r_zero      <= (w_prod_next[WIDTH-1:0] == '0);
      r_neg       <= w_prod_next[MSB];
      r_ovf       <= 1'b0;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, hand-written corner sequences and a
// randomized stream scored against an arithmetic reference model (WIDTH=8).
module tb_alu_pipe;
  localparam int W = 8;

  typedef struct {
    logic [2:0]    sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W+3:0]  exp;   // {result, carry, zero, neg, ovf}
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry, zero, neg, ovf;
  logic         dbg_state;
  logic [W+3:0] obs;

  int n_vec = 0;
  int n_err = 0;
  logic [W+3:0] exp_q[$];

  vec_t tbl[16];
  vec_t seq[5];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf),
    .o_dbg_state(dbg_state)
  );

  assign obs = {result, carry, zero, neg, ovf};

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic, signed range test for overflow.
  function automatic logic [W+3:0] model(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    int ai, bi, sa, sb, r, c, v, sh, full, half;
    full = 1 << W;
    half = 1 << (W - 1);
    ai = int'(x);
    bi = int'(y);
    sa = (ai >= half) ? ai - full : ai;
    sb = (bi >= half) ? bi - full : bi;
    sh = bi % W;
    c = 0;
    v = 0;
    case (s)
      3'd0: begin r = ai + bi; c = (r >= full) ? 1 : 0; v = ((sa + sb) >= half || (sa + sb) < -half) ? 1 : 0; end
      3'd1: begin r = ai - bi + full; c = (ai < bi) ? 1 : 0; v = ((sa - sb) >= half || (sa - sb) < -half) ? 1 : 0; end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin r = ai << sh; c = (sh > 0) ? ((ai >> (W - sh)) & 1) : 0; end
      3'd6: begin r = ai >> sh; c = (sh > 0) ? ((ai >> (sh - 1)) & 1) : 0; end
      default: begin r = ai * bi; c = ((r / full) != 0) ? 1 : 0; end
    endcase
    r = r % full;
    model = {r[W-1:0], c[0], (r == 0), (r >= half), v[0]};
  endfunction

  // Driver: present one op with out_ready high, wait for its result, check latency and value.
  task automatic do_op(input vec_t v);
    int waits;
    sel = v.sel; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("op_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 3'($urandom);
    waits = 0;
    while (!out_valid && waits < 40) begin
      check("busy_in_ready", in_ready, 0);
      step();
      waits++;
    end
    check("op_latency", waits, (v.sel == 3'b111) ? W : 0);
    check("op_result", obs, v.exp);
    step();
    check("op_drained", out_valid, 0);
  endtask

  initial begin
    // Directed table, values worked out by hand.
    tbl[0]  = '{3'd0, 8'hFF, 8'h01, {8'h00, 4'b1100}};
    tbl[1]  = '{3'd1, 8'h80, 8'h01, {8'h7F, 4'b0001}};
    tbl[2]  = '{3'd1, 8'h03, 8'h05, {8'hFE, 4'b1010}};
    tbl[3]  = '{3'd7, 8'h10, 8'h10, {8'h00, 4'b1100}};
    tbl[4]  = '{3'd7, 8'h0F, 8'h0D, {8'hC3, 4'b0010}};
    tbl[5]  = '{3'd7, 8'hFF, 8'hFF, {8'h01, 4'b1000}};
    tbl[6]  = '{3'd0, 8'h7F, 8'h01, {8'h80, 4'b0011}};
    tbl[7]  = '{3'd2, 8'hF0, 8'h3C, {8'h30, 4'b0000}};
    tbl[8]  = '{3'd3, 8'h81, 8'h02, {8'h83, 4'b0010}};
    tbl[9]  = '{3'd4, 8'h55, 8'h55, {8'h00, 4'b0100}};
    tbl[10] = '{3'd5, 8'h81, 8'h01, {8'h02, 4'b1000}};
    tbl[11] = '{3'd6, 8'h81, 8'h01, {8'h40, 4'b1000}};
    tbl[12] = '{3'd5, 8'h81, 8'h00, {8'h81, 4'b0010}};
    tbl[13] = '{3'd6, 8'h80, 8'h07, {8'h01, 4'b0000}};
    tbl[14] = '{3'd5, 8'hC0, 8'h09, {8'h80, 4'b1010}};
    tbl[15] = '{3'd7, 8'h00, 8'hA5, {8'h00, 4'b0100}};

    seq[0] = '{3'd2, 8'hF0, 8'h3C, {8'h30, 4'b0000}};
    seq[1] = '{3'd3, 8'h81, 8'h02, {8'h83, 4'b0010}};
    seq[2] = '{3'd4, 8'h55, 8'hAA, {8'hFF, 4'b0010}};
    seq[3] = '{3'd5, 8'h81, 8'h01, {8'h02, 4'b1000}};
    seq[4] = '{3'd6, 8'h81, 8'h01, {8'h40, 4'b1000}};

    // Reset state.
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", obs, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);

    // Table vectors, also cross-checked against the model.
    for (int i = 0; i < 16; i++) begin
      check("model_vs_table", model(tbl[i].sel, tbl[i].a, tbl[i].b), tbl[i].exp);
      do_op(tbl[i]);
    end

    // Back-to-back single-cycle ops: one result per clock, in order.
    out_ready = 1'b1;
    sel = seq[0].sel; a = seq[0].a; b = seq[0].b; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("b2b_in_ready", in_ready, 1);
      step();
      check("b2b_valid", out_valid, 1);
      check("b2b_result", obs, seq[i].exp);
      if (i < 4) begin
        sel = seq[i+1].sel; a = seq[i+1].a; b = seq[i+1].b;
      end else begin
        in_valid = 1'b0;
      end
      #1;
    end
    step();
    check("b2b_drained", out_valid, 0);

    // Backpressure: ADD held for 5 cycles, pending XOR taken on the drain edge.
    sel = 3'd0; a = 8'h05; b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    step();
    out_ready = 1'b0;
    sel = 3'd4; a = 8'h0F; b = 8'hF0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_hold", obs, {8'h08, 4'b0000});
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_xor_valid", out_valid, 1);
    check("bp_xor_result", obs, {8'hFF, 4'b0010});
    step();
    check("bp_drained", out_valid, 0);

    // Reset in the middle of a multiply: no result may ever appear.
    sel = 3'd7; a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_outputs", obs, 0);
    check("mrst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    #1 check("mrst_release_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("mrst_no_stale", out_valid, 0);
    end
    do_op(tbl[4]);

    // Randomized stream with random backpressure, scored against the model.
    begin
      logic [W+3:0] prev_out;
      logic         prev_hold;
      logic         acc, drn;
      int           stall;
      prev_hold = 1'b0;
      prev_out  = '0;
      stall     = 0;
      for (int c = 0; c < 600; c++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        sel = 3'($urandom_range(0, 7));
        a   = W'($urandom_range(0, 255));
        b   = W'($urandom_range(0, 255));
        #1;
        if (prev_hold) begin
          check("rnd_hold_valid", out_valid, 1);
          check("rnd_hold_value", obs, prev_out);
        end
        if (out_valid && !out_ready) check("rnd_hold_in_ready", in_ready, 0);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
          if (exp_q.size() == 0) fail("rnd_spurious_result");
          else check("rnd_result", obs, exp_q.pop_front());
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = obs;
        if (acc) exp_q.push_back(model(sel, a, b));
        step();
        if (exp_q.size() > 0 && !drn) stall++;
        else stall = 0;
        if (stall > 60) begin
          fail("rnd_timeout");
          break;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
        #1;
        if (out_valid) check("rnd_tail_result", obs, exp_q.pop_front());
        step();
      end
      check("rnd_queue_empty", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU. Supports WIDTH-bit operands, a full flag set (carry, zero, negative, overflow) and a multi-cycle shift-add multiply.
- Uses valid/ready handshakes on input and output, so it drops directly into datapath pipelines.
- One operation is in flight at a time. Single-cycle ops sustain one result per clock under continuous out_ready.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2, power of two); shift amount width SW = $clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A (unsigned; signed view for overflow).
- b  in  WIDTH  operand B; for shifts, shift amount = b[SW-1:0].
- sel  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- carry  out  1  carry/borrow/shift-out/mul-high flag.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- ovf  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (async assert, synchronous-to-clk deassert use): state=IDLE, out_valid=0, result=0, all flags=0, in_ready=0 while rst_n low. Reset mid-MUL aborts the multiply; no result is produced.
- FSM states:
  - IDLE: accepts operations.
  - BUSY: multiply in progress.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready at a rising edge. a, b and sel are sampled only on accept.
- Output drain = out_valid && out_ready at an edge. out_valid clears unless a new result loads on the same edge.
- Single-cycle ops (sel != 111): accept at edge k → result/flags loaded and out_valid=1 at edge k. Latency is 1 clock. Accept and drain on the same edge replace the output with no bubble.
- MUL: accept at edge k → state BUSY. Internal 2*WIDTH product accumulator and iteration counter are loaded.
  - One multiplier bit is processed per edge, at k+1 .. k+WIDTH.
  - At edge k+WIDTH: result = product[WIDTH-1:0], carry = |product[2*WIDTH-1:WIDTH], out_valid=1, state → IDLE.
  - in_ready=0 throughout BUSY. out_valid=0 throughout BUSY, because the previous result drained on the accept edge.
- Output hold: while out_valid && !out_ready, result and flags are stable and in_ready=0.
- Flag rules:
  - ADD: carry = bit WIDTH of a+b (WIDTH+1-bit sum). ovf = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - SUB: result = a-b mod 2^WIDTH; carry = borrow (a<b unsigned). ovf = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - AND/OR/XOR: carry=0, ovf=0.
  - SHL by s: carry = a[WIDTH-s] if s>0, else 0. SHR by s: carry = a[s-1] if s>0, else 0. Shifts of s=0 pass a through. ovf=0 for both.
  - MUL: unsigned; ovf=0.
  - zero and neg are derived from the final result for all ops.
- Inputs are ignored when in_valid=0 or in_ready=0. No X propagation is permitted from unsampled inputs.

Test Plan (WIDTH=8):
- ADD a=FF, b=01, out_ready=1 → next cycle out_valid=1, result=00, carry=1, zero=1, neg=0, ovf=0.
- SUB a=80, b=01 → result=7F, carry=0, ovf=1, neg=0; then SUB a=03, b=05 → result=FE, carry=1, neg=1, ovf=0.
- MUL a=10, b=10, accepted at edge k → in_ready=0 and out_valid=0 for edges k+1..k+7; at edge k+8, out_valid=1, result=00, carry=1, zero=1. MUL a=0F, b=0D → result=C3, carry=0.
- Back-to-back AND/OR/XOR/SHL(a=81, b=01 → 02, carry=1)/SHR(a=81, b=01 → 40, carry=1) with in_valid and out_ready held high → one result per clock in order, in_ready stays 1.
- Backpressure: out_ready=0 after ADD 05+03 → result=08 held stable and in_ready=0 for 5 cycles. Raising out_ready drains it, and a pending XOR is accepted on the same edge.
- Reset asserted at edge k+4 of a MUL → out_valid=0, result=0, flags=0 immediately. After release, in_ready=1 and no stale product ever appears.
